dl_down_counter: RTL and testbench

DL_DOWN_COUNTER -- requirements
Module: dl_down_counter

---
 rtl/dl_down_counter.sv | 124 ++++++++++++
 tb/tb_dl_down_counter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dl_down_counter.sv
// dl_down_counter: loadable down-counter with pause (en), abort and a one-cycle expiry pulse (done).
// Latency: q, busy and done are registered; each changes on the rising edge after a load, count step or abort.
// Backpressure: load_ready is low in RUN, so loads are taken only in IDLE or DONE; macro DL_DOWN_COUNTER_RELOAD_EN adds auto-reload.
module dl_down_counter #(
   parameter int NUM_BITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
`ifdef DL_DOWN_COUNTER_RELOAD_EN
   input  logic                reload_en,
`endif
   input  logic                load_valid,
   output logic                load_ready,
   input  logic [NUM_BITS-1:0] load_val,
   input  logic                en,
   input  logic                abort,
   output logic [NUM_BITS-1:0] q,
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [NUM_BITS-1:0] count_q, count_d;
   logic                done_q, done_d;
   logic                load_acc;

`ifdef DL_DOWN_COUNTER_RELOAD_EN
   logic [NUM_BITS-1:0] reload_q, reload_d;
`endif

   // Handshake and status are decoded from the state register alone.
   assign load_ready = (state_q == S_IDLE) || (state_q == S_DONE);
   assign busy       = (state_q == S_RUN);
   assign load_acc   = load_valid && load_ready;
   assign q          = count_q;
   assign done       = done_q;

   // Next-state logic: load in IDLE/DONE, abort > count step in RUN, DONE lasts one cycle.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      done_d   = 1'b0;
`ifdef DL_DOWN_COUNTER_RELOAD_EN
      reload_d = reload_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (load_acc) begin
               count_d  = load_val;
`ifdef DL_DOWN_COUNTER_RELOAD_EN
               reload_d = load_val;
`endif
               if (load_val == '0) begin
                  // A zero load expires immediately without ever running.
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_RUN;
               end
            end else if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (abort) begin
               // Abort wins over decrement and expiry; q is frozen where it stood.
               state_d = S_IDLE;
            end else if (en) begin
               if (count_q > NUM_BITS'(1)) begin
                  count_d = count_q - NUM_BITS'(1);
               end else begin
                  // Expiry step; the <= 1 test also keeps q from wrapping below zero.
                  done_d = 1'b1;
`ifdef DL_DOWN_COUNTER_RELOAD_EN
                  if (reload_en) begin
                     count_d = reload_q;
                  end else begin
                     count_d = '0;
                     state_d = S_DONE;
                  end
`else
                  count_d = '0;
                  state_d = S_DONE;
`endif
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, count and pulse registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

`ifdef DL_DOWN_COUNTER_RELOAD_EN
   // Reload value captured on every accepted load.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         reload_q <= '0;
      end else begin
         reload_q <= reload_d;
      end
   end
`endif

endmodule

// File: tb/tb_dl_down_counter.sv
// tb_dl_down_counter: directed stimulus with a per-cycle reference model and literal spot checks.
// Latency: model expectations refer to the outputs after each rising edge, compared on the falling edge.
// Backpressure: loads are only offered; the model decides acceptance from its own notion of the mode.
module tb_dl_down_counter;

   logic       clk;
   logic       rst_n;
   logic       load_valid;
   logic       load_ready;
   logic [3:0] load_val;
   logic       en;
   logic       abort;
   logic [3:0] q;
   logic       busy;
   logic       done;
`ifdef DL_DOWN_COUNTER_RELOAD_EN
   logic       reload_en;
`endif

   int n_pass  = 0;
   int n_total = 0;

   dl_down_counter #(.NUM_BITS(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef DL_DOWN_COUNTER_RELOAD_EN
      .reload_en  (reload_en),
`endif
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_val   (load_val),
      .en         (en),
      .abort      (abort),
      .q          (q),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: mode 0 = idle, 1 = counting, 2 = just expired.
   int         m_mode  = 0;
   int         m_q     = 0;
   int         m_rel   = 0;
   int         m_done  = 0;
   bit         m_valid = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_mode  = 0;
         m_q     = 0;
         m_done  = 0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         m_done = 0;
         if (m_mode != 1 && load_valid) begin
            m_q   = int'(load_val);
            m_rel = int'(load_val);
            if (m_q == 0) begin
               m_mode = 2;
               m_done = 1;
            end else begin
               m_mode = 1;
            end
         end else if (m_mode == 2) begin
            m_mode = 0;
         end else if (m_mode == 1 && abort) begin
            m_mode = 0;
         end else if (m_mode == 1 && en) begin
            if (m_q == 1) begin
               m_done = 1;
`ifdef DL_DOWN_COUNTER_RELOAD_EN
               if (reload_en) begin
                  m_q = m_rel;
               end else begin
                  m_q    = 0;
                  m_mode = 2;
               end
`else
               m_q    = 0;
               m_mode = 2;
`endif
            end else begin
               m_q = m_q - 1;
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("cyc_q",     int'(q),          m_q);
         chk("cyc_busy",  int'(busy),       int'(m_mode == 1));
         chk("cyc_ready", int'(load_ready), int'(m_mode != 1));
         chk("cyc_done",  int'(done),       m_done);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic expect_out(input string name, input int eq, input int eb, input int ed, input int er);
      chk({name, "_q"},     int'(q),          eq);
      chk({name, "_busy"},  int'(busy),       eb);
      chk({name, "_done"},  int'(done),       ed);
      chk({name, "_ready"}, int'(load_ready), er);
   endtask

   int q030 [4] = '{3, 2, 1, 0};
   int en031[6] = '{1, 0, 0, 1, 1, 1};
   int q031 [6] = '{3, 3, 3, 2, 1, 0};
   int q035 [4] = '{1, 2, 1, 2};

   initial begin
      rst_n = 1'b0; load_valid = 1'b0; load_val = 4'd0; en = 1'b0; abort = 1'b0;
`ifdef DL_DOWN_COUNTER_RELOAD_EN
      reload_en = 1'b0;
`endif
      cyc(); cyc();
      expect_out("reset", 0, 0, 0, 1);
      rst_n = 1'b1;

      // Load 3, count down to expiry.
      load_valid = 1'b1; load_val = 4'd3; en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         load_valid = 1'b0;
         chk("r030_q", int'(q), q030[i]);
         chk("r030_busy", int'(busy), int'(i < 3));
         chk("r030_done", int'(done), int'(i == 3));
      end
      cyc();
      expect_out("r030_after", 0, 0, 0, 1);

      // Load 4 with pauses.
      load_valid = 1'b1; load_val = 4'd4; cyc(); load_valid = 1'b0;
      expect_out("r031_load", 4, 1, 0, 0);
      for (int i = 0; i < 6; i++) begin
         en = en031[i][0];
         cyc();
         chk("r031_q", int'(q), q031[i]);
         chk("r031_done", int'(done), int'(i == 5));
      end
      en = 1'b1;
      cyc();
      expect_out("r031_after", 0, 0, 0, 1);

      // Load 9, abort at 5.
      load_valid = 1'b1; load_val = 4'd9; cyc(); load_valid = 1'b0;
      expect_out("r032_load", 9, 1, 0, 0);
      repeat (4) cyc();
      expect_out("r032_at5", 5, 1, 0, 0);
      abort = 1'b1; cyc(); abort = 1'b0;
      expect_out("r032_abort", 5, 0, 0, 1);
      cyc();
      expect_out("r032_idle", 5, 0, 0, 1);

      // Zero load, then back-to-back load of 5 from DONE.
      load_valid = 1'b1; load_val = 4'd0; cyc();
      expect_out("r033_zero", 0, 0, 1, 1);
      load_val = 4'd5; cyc(); load_valid = 1'b0;
      expect_out("r033_b2b", 5, 1, 0, 0);
      repeat (4) cyc();
      expect_out("r033_at1", 1, 1, 0, 0);
      cyc();
      expect_out("r033_exp", 0, 0, 1, 1);
      cyc();

      // Load 6, load_valid held in RUN, reset at 3.
      load_valid = 1'b1; load_val = 4'd6; cyc(); load_val = 4'd2;
      expect_out("r034_load", 6, 1, 0, 0);
      repeat (3) cyc();
      expect_out("r034_at3", 3, 1, 0, 0);
      rst_n = 1'b0; cyc(); rst_n = 1'b1; load_valid = 1'b0;
      expect_out("r034_rst", 0, 0, 0, 1);
      cyc();
      expect_out("r034_post", 0, 0, 0, 1);

      // Abort ignored in IDLE and DONE.
      abort = 1'b1; load_valid = 1'b1; load_val = 4'd1; cyc(); load_valid = 1'b0; abort = 1'b0;
      expect_out("abt_idle", 1, 1, 0, 0);
      cyc();
      expect_out("abt_exp1", 0, 0, 1, 1);
      abort = 1'b1; cyc(); abort = 1'b0;
      expect_out("abt_done", 0, 0, 0, 1);

      // Abort beats expiry at q == 1.
      load_valid = 1'b1; load_val = 4'd2; cyc(); load_valid = 1'b0;
      cyc();
      expect_out("abt_at1", 1, 1, 0, 0);
      abort = 1'b1; cyc(); abort = 1'b0;
      expect_out("abt_win", 1, 0, 0, 1);

      // Maximum load value, paused then stepped.
      load_valid = 1'b1; load_val = 4'd15; en = 1'b0; cyc(); load_valid = 1'b0;
      repeat (3) cyc();
      expect_out("max_hold", 15, 1, 0, 0);
      en = 1'b1; cyc();
      expect_out("max_step", 14, 1, 0, 0);
      abort = 1'b1; cyc(); abort = 1'b0;
      expect_out("max_abort", 14, 0, 0, 1);

`ifdef DL_DOWN_COUNTER_RELOAD_EN
      // Auto-reload of 2, then release reload_en.
      reload_en = 1'b1; load_valid = 1'b1; load_val = 4'd2; cyc(); load_valid = 1'b0;
      expect_out("r035_load", 2, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("r035_q", int'(q), q035[i]);
         chk("r035_done", int'(done), int'(q035[i] == 2));
         chk("r035_busy", int'(busy), 1);
      end
      reload_en = 1'b0; cyc();
      expect_out("r035_noreload", 1, 1, 0, 0);
      cyc();
      expect_out("r035_end", 0, 0, 1, 1);
      reload_en = 1'b1; load_valid = 1'b1; load_val = 4'd0; cyc(); load_valid = 1'b0;
      expect_out("r035_zero", 0, 0, 1, 1);
      cyc();
      expect_out("r035_idle", 0, 0, 0, 1);
`endif

      repeat (2) cyc();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
